fifo_write_sequencer: RTL and testbench

Write-side traffic source for the dual async-FIFO loopback wrapper: generates a programmable burst of data words on `din`/`wen` in the `wclk` domain and honours the FIFO `full` flag so no write is ever lost. It sits directly upstream of the first FIFO stage, with `din`, `wen` and `full1` wired point-to-point. Software or a test controller kicks a burst with `start`. Status outputs report completion, words written and back-pressure cycles.

---
 rtl/fifo_write_sequencer.sv | 140 ++++++++++++++
 tb/tb_fifo_write_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_sequencer.sv
// Write-side burst generator for the async-FIFO loopback: emits a programmable
// pattern burst on din/wen, honouring full and pause, and reports status counters.
module fifo_write_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  pause,
    input  logic                  full,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  wen,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  wr_count,
    output logic [15:0]           stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_r;
    state_t                  state_s;
    logic                    wen_s;
    logic [LEN_WIDTH-1:0]    len_r;
    logic [1:0]              mode_r;
    logic [DATA_WIDTH-1:0]   seed_r;
    logic [DATA_WIDTH-1:0]   din_r;
    logic [LEN_WIDTH-1:0]    wr_count_r;
    logic [15:0]             stall_count_r;

    // Pattern word that follows cur once a write is accepted.
    function automatic logic [DATA_WIDTH-1:0] next_word(
        input logic [DATA_WIDTH-1:0] cur,
        input logic [1:0]            m,
        input logic [DATA_WIDTH-1:0] sd
    );
        logic [DATA_WIDTH-1:0] nw;
        case (m)
            2'd0:    nw = cur + DATA_ONE;
            2'd1:    nw = cur - DATA_ONE;
            2'd2:    nw = sd;
            2'd3:    nw = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1]};
            default: nw = cur;
        endcase
        return nw;
    endfunction

    // Next-state decode and the zero-latency write enable.
    always_comb begin
        state_s = state_r;
        wen_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (burst_len == LEN_ZERO) begin
                        state_s = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                wen_s = ~full & ~pause;
                if (wen_s && (wr_count_r == (len_r - LEN_ONE))) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, latched burst parameters, data word and status counters.
    always_ff @(posedge wclk) begin
        if (rst) begin
            state_r       <= IDLE;
            len_r         <= LEN_ZERO;
            mode_r        <= 2'd0;
            seed_r        <= DATA_ZERO;
            din_r         <= DATA_ZERO;
            wr_count_r    <= LEN_ZERO;
            stall_count_r <= 16'h0000;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r         <= burst_len;
                        mode_r        <= mode;
                        seed_r        <= seed;
                        din_r         <= seed;
                        wr_count_r    <= LEN_ZERO;
                        stall_count_r <= 16'h0000;
                    end
                end
                RUN: begin
                    if (wen_s) begin
                        din_r      <= next_word(din_r, mode_r, seed_r);
                        wr_count_r <= wr_count_r + LEN_ONE;
                    end
                    // Full cycles are back-pressure even when pause is also high.
                    if (full && (stall_count_r != 16'hFFFF)) begin
                        stall_count_r <= stall_count_r + 16'h0001;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign din         = din_r;
    assign wen         = wen_s;
    assign busy        = (state_r == RUN);
    assign done        = (state_r == DONE);
    assign wr_count    = wr_count_r;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_fifo_write_sequencer.sv
// Self-checking bench for fifo_write_sequencer: directed scenarios plus random
// bursts compared against an arithmetic model of the pattern and counters.
module tb_fifo_write_sequencer;

    logic        wclk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  burst_len;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic        pause;
    logic        full;
    logic [7:0]  din;
    logic        wen;
    logic        busy;
    logic        done;
    logic [7:0]  wr_count;
    logic [15:0] stall_count;

    int vectors = 0;
    int miscompares = 0;

    fifo_write_sequencer #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .wclk(wclk), .rst(rst), .start(start), .burst_len(burst_len),
        .mode(mode), .seed(seed), .pause(pause), .full(full),
        .din(din), .wen(wen), .busy(busy), .done(done),
        .wr_count(wr_count), .stall_count(stall_count)
    );

    always #5 wclk = ~wclk;

    // i-th word of a burst, computed directly from seed and index.
    function automatic logic [7:0] pattern_word(input logic [7:0] sd, input int md, input int i);
        logic [15:0] dbl;
        case (md)
            0: return sd + 8'(i);
            1: return sd - 8'(i);
            2: return sd;
            default: begin
                dbl = {sd, sd} << (i % 8);
                return dbl[15:8];
            end
        endcase
    endfunction

    // Issue a start pulse; returns at edge E + 1 time unit.
    task automatic kick(input int len, input int md, input logic [7:0] sd);
        start = 1'b1; burst_len = 8'(len); mode = 2'(md); seed = sd;
        @(posedge wclk); #1;
        start = 1'b0;
    endtask

    // Run one burst from cycle E+1 to its done cycle, checking every cycle.
    // full/pause are forced high within [lo,hi] cycle windows and randomly with pct.
    task automatic run_burst(input int len, input int md, input logic [7:0] sd,
                             input int full_lo, input int full_hi,
                             input int pause_lo, input int pause_hi,
                             input int pct, input bit restart,
                             output int span, output int exp_stalls);
        int k;
        bit f, p, ew, finished;
        k = 0; exp_stalls = 0; span = 0; finished = 1'b0;
        kick(len, md, sd);
        for (int c = 1; c <= 400 && !finished; c++) begin
            f = (c >= full_lo && c <= full_hi) || (pct > 0 && $urandom_range(99) < pct);
            p = (c >= pause_lo && c <= pause_hi) || (pct > 0 && $urandom_range(99) < pct);
            full = f; pause = p;
            start = restart && (c == 2 || c == 3);
            burst_len = restart ? 8'd5 : burst_len;
            @(negedge wclk);
            vectors++;
            if (k < len) begin
                ew = !f && !p;
                if ({busy, done, wen} !== {1'b1, 1'b0, ew}) begin
                    miscompares++;
                    $display("FAIL run_status cyc=%0d busy/done/wen got %b%b%b want 1 0 %b", c, busy, done, wen, ew);
                end
                if (ew) begin
                    vectors++;
                    if (din !== pattern_word(sd, md, k)) begin
                        miscompares++;
                        $display("FAIL din word%0d got %h want %h", k, din, pattern_word(sd, md, k));
                    end
                    k++;
                end
                if (f) exp_stalls++;
            end else begin
                if ({busy, done, wen} !== 3'b010) begin
                    miscompares++;
                    $display("FAIL done_cycle cyc=%0d busy/done/wen got %b%b%b want 010", c, busy, done, wen);
                end
                span = c;
                finished = 1'b1;
            end
            @(posedge wclk); #1;
        end
        full = 1'b0; pause = 1'b0; start = 1'b0;
        if (!finished) begin
            vectors++; miscompares++;
            $display("FAIL burst_timeout got %0d writes want %0d", k, len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; burst_len = 8'd0; mode = 2'd0; seed = 8'd0;
        pause = 1'b0; full = 1'b0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        vectors++;
        if ({din, wen, busy, done, wr_count, stall_count} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_state got din=%h wen=%b busy=%b done=%b wc=%0d sc=%0d want all 0",
                     din, wen, busy, done, wr_count, stall_count);
        end
        @(posedge wclk); #1;
        rst = 1'b0;
    endtask

    task automatic check_counts(input string name, input int wc, input int sc);
        vectors++;
        if (wr_count !== 8'(wc) || stall_count !== 16'(sc)) begin
            miscompares++;
            $display("FAIL %s counts got wc=%0d sc=%0d want wc=%0d sc=%0d", name, wr_count, stall_count, wc, sc);
        end
    endtask

    task automatic test_basic();
        int span, st;
        run_burst(4, 0, 8'hFE, 0, -1, 0, -1, 0, 1'b0, span, st);
        vectors++;
        if (span !== 5) begin
            miscompares++;
            $display("FAIL basic_done_cycle got %0d want 5", span);
        end
        check_counts("basic", 4, 0);
    endtask

    task automatic test_back_pressure();
        int span, st;
        run_burst(3, 1, 8'h02, 2, 6, 0, -1, 0, 1'b0, span, st);
        vectors++;
        if (span !== 9) begin
            miscompares++;
            $display("FAIL backpressure_span got done at %0d want 9", span);
        end
        check_counts("backpressure", 3, 5);
    endtask

    task automatic test_walking_pause();
        int span, st;
        run_burst(9, 3, 8'h01, 0, -1, 4, 5, 0, 1'b0, span, st);
        vectors++;
        if (span !== 12) begin
            miscompares++;
            $display("FAIL walking_span got done at %0d want 12", span);
        end
        check_counts("walking", 9, 0);
    endtask

    task automatic test_zero_and_ignored();
        int span, st;
        run_burst(0, 0, 8'h33, 0, -1, 0, -1, 0, 1'b0, span, st);
        vectors++;
        if (span !== 1) begin
            miscompares++;
            $display("FAIL zero_len_done got done at %0d want 1", span);
        end
        check_counts("zero_len", 0, 0);
        run_burst(6, 0, 8'h10, 0, -1, 0, -1, 0, 1'b1, span, st);
        check_counts("ignored_start", 6, 0);
        // Stay idle: no write and no busy after the burst.
        @(negedge wclk);
        vectors++;
        if ({busy, wen, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL post_burst_idle got busy/wen/done %b%b%b want 000", busy, wen, done);
        end
        @(posedge wclk); #1;
    endtask

    task automatic test_reset_mid_burst();
        int span, st;
        kick(5, 0, 8'h40);
        for (int c = 0; c < 2; c++) begin
            @(negedge wclk);
            vectors++;
            if (wen !== 1'b1 || din !== 8'(8'h40 + c)) begin
                miscompares++;
                $display("FAIL pre_reset_write%0d got wen=%b din=%h want 1 %h", c, wen, din, 8'(8'h40 + c));
            end
            @(posedge wclk); #1;
        end
        rst = 1'b1;
        @(posedge wclk); #1;
        rst = 1'b0;
        vectors++;
        if ({din, wen, busy, done, wr_count, stall_count} !== 35'd0) begin
            miscompares++;
            $display("FAIL mid_reset got din=%h wen=%b busy=%b done=%b wc=%0d sc=%0d want all 0",
                     din, wen, busy, done, wr_count, stall_count);
        end
        run_burst(2, 2, 8'hA5, 0, -1, 0, -1, 0, 1'b0, span, st);
        vectors++;
        if (span !== 3) begin
            miscompares++;
            $display("FAIL after_reset_span got %0d want 3", span);
        end
        check_counts("after_reset", 2, 0);
    endtask

    task automatic test_random();
        int span, st, len, md;
        logic [7:0] sd;
        for (int b = 0; b < 25; b++) begin
            len = $urandom_range(20, 1);
            md  = $urandom_range(3);
            sd  = 8'($urandom);
            run_burst(len, md, sd, 0, -1, 0, -1, 30, 1'b0, span, st);
            check_counts("random", len, st);
            repeat ($urandom_range(2)) @(posedge wclk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_walking_pause();
        test_zero_and_ignored();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
